// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time program loader.
//   loader_state_t     : loader FSM states
//   SYNC_BYTE_DEFAULT  : frame start marker
//   LEN_W              : width of the frame length field (words)
//   length_ok()        : true when a frame length can be loaded into memory
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_W             = 16;

  // A frame must carry at least one word and must fit in instruction memory.
  function automatic logic length_ok(input logic [LEN_W-1:0] len, input int num_words);
    return (len != '0) && (int'(len) <= num_words);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects bytes into little-endian 32-bit words (first byte -> bits[7:0]).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : restart packing at byte 0 of a new word
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   word_valid  : combinational pulse while the 4th byte of a word is presented
//   word_data   : the completed word, valid together with word_valid
// ---------------------------------------------------------------------------
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // Bytes enter at the top and move down, so after three bytes the oldest
  // one sits in bits[7:0]; the 2-bit counter wraps naturally every word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {byte_data, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The 4th byte completes the word directly, without waiting for a register
  // stage, so the loader can register the write one cycle later.
  always_comb begin
    word_valid = byte_valid && (cnt_q == 2'd3);
    word_data  = {byte_data, shift_q};
  end

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Boot-time program loader: frames a byte stream (SYNC, LEN_LO, LEN_HI, then
// 4*N little-endian data bytes), writes the packed words into instruction
// memory and holds the CPU core in reset until a complete image is loaded.
// Optional feature macro: LOADER_CHECKSUM_EN -- when defined, one extra byte
// equal to the XOR of all data bytes must follow the payload.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_valid     : byte available on rx_data
//   rx_data      : incoming byte
//   rx_ready     : loader accepts bytes (always 1 out of reset)
//   imem_we      : one-cycle write strobe per word
//   imem_addr    : word address being written
//   imem_wdata   : word being written
//   core_rst     : 1 holds the CPU core in reset
//   busy         : frame in progress
//   done         : last frame loaded successfully
//   error        : last frame rejected
// ---------------------------------------------------------------------------
module prog_loader
  import loader_pkg::*;
#(
  parameter int         WORD_SIZE = 32,
  parameter int         NUM_WORDS = 1024,
  parameter int         ADDR_SIZE = $clog2(NUM_WORDS),
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 imem_we,
  output logic [ADDR_SIZE-1:0] imem_addr,
  output logic [WORD_SIZE-1:0] imem_wdata,
  output logic                 core_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  loader_state_t state_q, state_d;

  logic             accept;
  logic [7:0]       len_lo_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] full_len;
  logic [ADDR_SIZE:0] word_idx_q;
  logic             pk_valid;
  logic             pk_clear;
  logic             word_valid;
  logic [31:0]      word_data;
  logic             last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  // A handshake happens on every presented byte once out of reset; all FSM
  // progress and data capture key off this single strobe.
  always_comb begin
    accept    = rx_valid && rx_ready;
    full_len  = {rx_data, len_lo_q};
    pk_valid  = accept && (state_q == DATA);
    pk_clear  = accept && (state_q == LEN_HI);
    last_word = word_valid && ((LEN_W'(word_idx_q) + LEN_W'(1)) == len_q);
  end

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The FSM only moves on an accepted byte; a sync byte
  // inside the header or payload is ordinary data, so only the resting
  // states look for it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = LEN_LO;
          end
        end
        LEN_LO: state_d = LEN_HI;
        LEN_HI: state_d = length_ok(full_len, NUM_WORDS) ? DATA : ERROR;
        DATA: begin
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: state_d = (rx_data == csum_q) ? DONE : ERROR;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are a plain decode of the state register, so done and
  // the core_rst release appear the cycle after DONE is entered.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    core_rst = 1'b1;
    unique case (state_q)
      LEN_LO, LEN_HI, DATA, CHK: busy = 1'b1;
      DONE: begin
        done     = 1'b1;
        core_rst = 1'b0;
      end
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, word index and the registered memory write.
  // The write is registered so imem_we lands one cycle after the 4th byte;
  // address and data hold their last values between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
    end else begin
      rx_ready <= 1'b1;
      imem_we  <= word_valid;
      if (word_valid) begin
        imem_addr  <= word_idx_q[ADDR_SIZE-1:0];
        imem_wdata <= WORD_SIZE'(word_data);
        word_idx_q <= word_idx_q + 1'b1;
      end
      if (accept && (state_q == LEN_LO)) begin
        len_lo_q <= rx_data;
      end
      if (pk_clear) begin
        len_q      <= full_len;
        word_idx_q <= '0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every payload byte, restarted with each new length.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (pk_clear) begin
      csum_q <= '0;
    end else if (pk_valid) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader. A byte-level frame model (queue of frame
// bytes since the last sync) predicts status outputs and memory writes each
// cycle; literal expectations pin the model at key points.
// Honours LOADER_CHECKSUM_EN (appends the XOR byte to every frame).
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int NUM_WORDS = 1024;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  prog_loader #(.NUM_WORDS(NUM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int num_compared   = 0;
  int num_mismatched = 0;

  // Model state: frame bytes received since the sync byte, last frame result.
  logic [7:0]  q[$];
  logic        in_frame     = 1'b0;
  int          status       = 0;
  int          n_words      = 0;
  logic        exp_rx_ready = 1'b0;
  logic        exp_we       = 1'b0;
  logic [9:0]  exp_addr     = '0;
  logic [31:0] exp_data     = '0;
  logic [31:0] exp_mem [0:NUM_WORDS-1];
  logic        checking     = 1'b0;

  // Memory image as seen on the DUT write port, plus write counters.
  logic [31:0] dut_mem [0:NUM_WORDS-1];
  int          total_writes = 0;
  int          addr0_writes = 0;

  logic [7:0]  frame_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    in_frame     = 1'b0;
    status       = 0;
    exp_rx_ready = 1'b0;
    q.delete();
  endtask

  // Interpret one accepted byte against the frame format.
  task automatic model_byte(input logic [7:0] b);
    int k;
    logic [7:0] x;
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1'b1;
        q.delete();
      end
    end else begin
      q.push_back(b);
      if (q.size() == 2) begin
        n_words = int'({q[1], q[0]});
        if (n_words == 0 || n_words > NUM_WORDS) begin
          in_frame = 1'b0;
          status   = 2;
        end
      end else begin
        k = q.size() - 2;
        if (k <= 4 * n_words && k % 4 == 0) begin
          exp_we   = 1'b1;
          exp_addr = 10'(k / 4 - 1);
          exp_data = {q[k+1], q[k], q[k-1], q[k-2]};
          exp_mem[exp_addr] = exp_data;
`ifndef LOADER_CHECKSUM_EN
          if (k == 4 * n_words) begin
            in_frame = 1'b0;
            status   = 1;
          end
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        if (k == 4 * n_words + 1) begin
          x = 8'h00;
          for (int i = 2; i < 4 * n_words + 2; i++) x = x ^ q[i];
          status   = (b == x) ? 1 : 2;
          in_frame = 1'b0;
        end
`endif
      end
    end
  endtask

  // Advance one clock, then update the model with what the DUT sampled.
  task automatic tick();
    logic s_rst, acc;
    logic [7:0] s_data;
    s_rst  = rst;
    s_data = rx_data;
    acc    = rx_valid && exp_rx_ready && !s_rst;
    @(posedge clk);
    #1;
    exp_we = 1'b0;
    if (s_rst) begin
      model_reset();
    end else begin
      exp_rx_ready = 1'b1;
      if (acc) model_byte(s_data);
    end
    checking = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    rx_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic resetDut(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    tick();
  endtask

  // Sends sync, length and frame_q as payload (plus the XOR byte when enabled).
  task automatic send_frame(input int max_gap);
    int n;
    logic [7:0] x;
    n = frame_q.size() / 4;
    x = 8'h00;
    applyStimulus(8'hA5, $urandom_range(max_gap, 0));
    applyStimulus(n[7:0], $urandom_range(max_gap, 0));
    applyStimulus(n[15:8], $urandom_range(max_gap, 0));
    foreach (frame_q[i]) begin
      x = x ^ frame_q[i];
      applyStimulus(frame_q[i], $urandom_range(max_gap, 0));
    end
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(x, $urandom_range(max_gap, 0));
`endif
  endtask

  // Capture every write the DUT issues.
  always @(posedge clk) begin
    if (imem_we === 1'b1) begin
      dut_mem[imem_addr] <= imem_wdata;
      total_writes       <= total_writes + 1;
      if (imem_addr == 10'd0) addr0_writes <= addr0_writes + 1;
    end
  end

  // Every cycle, away from the active edge, compare the DUT with the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("rx_ready", {31'd0, rx_ready}, {31'd0, exp_rx_ready});
      checkOutput("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
      checkOutput("busy", {31'd0, busy}, {31'd0, in_frame});
      checkOutput("done", {31'd0, done}, {31'd0, !in_frame && status == 1});
      checkOutput("error", {31'd0, error}, {31'd0, !in_frame && status == 2});
      checkOutput("core_rst", {31'd0, core_rst}, {31'd0, !(!in_frame && status == 1)});
      if (exp_we) begin
        checkOutput("imem_addr", {22'd0, imem_addr}, {22'd0, exp_addr});
        checkOutput("imem_wdata", imem_wdata, exp_data);
      end
    end
  end

  // Directed test sequence.
  initial begin
    int snap;

    // Reset behaviour.
    repeat (3) tick();
    checkOutput("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("rst_core_rst", {31'd0, core_rst}, 32'd1);
    checkOutput("rst_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // Two-word frame without gaps.
    $display("[TB] two-word frame");
    frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(0);
    idle(2);
    checkOutput("t2_mem0", dut_mem[0], 32'h00000013);
    checkOutput("t2_mem1", dut_mem[1], 32'h00100093);
    checkOutput("t2_model_mem1", exp_mem[1], 32'h00100093);
    checkOutput("t2_done", {31'd0, done}, 32'd1);
    checkOutput("t2_core_rst", {31'd0, core_rst}, 32'd0);

    // Illegal lengths, then a valid frame.
    $display("[TB] illegal lengths");
    snap = total_writes;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    idle(1);
    checkOutput("t3_len0_error", {31'd0, error}, 32'd1);
    checkOutput("t3_len0_core_rst", {31'd0, core_rst}, 32'd1);
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h04, 0);
    idle(1);
    checkOutput("t3_len401_error", {31'd0, error}, 32'd1);
    checkOutput("t3_no_writes", total_writes, snap);
    frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(0);
    idle(1);
    checkOutput("t3_error_cleared", {31'd0, error}, 32'd0);
    checkOutput("t3_done", {31'd0, done}, 32'd1);
    checkOutput("t3_mem0", dut_mem[0], 32'h04030201);

    // Junk in IDLE and random gaps.
    $display("[TB] junk and gaps");
    resetDut(2);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h5A, 2);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h13, 3);
    idle(1);
    checkOutput("t4_junk_busy", {31'd0, busy}, 32'd0);
    frame_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(3);
    idle(2);
    checkOutput("t4_mem0", dut_mem[0], 32'h00000013);
    checkOutput("t4_mem1", dut_mem[1], 32'h00100093);
    checkOutput("t4_done", {31'd0, done}, 32'd1);

    // Reset in the middle of a frame.
    $display("[TB] mid-frame reset");
    snap = addr0_writes;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'hEF, 0);
    applyStimulus(8'hBE, 0);
    applyStimulus(8'hAD, 0);
    applyStimulus(8'hDE, 0);
    applyStimulus(8'h77, 0);
    resetDut(2);
    checkOutput("t5_addr0_once", addr0_writes - snap, 32'd1);
    checkOutput("t5_mem0", dut_mem[0], 32'hDEADBEEF);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_core_rst", {31'd0, core_rst}, 32'd1);
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(0);
    idle(1);
    checkOutput("t5_first_done", {31'd0, core_rst}, 32'd0);
    applyStimulus(8'hA5, 0);
    checkOutput("t5_reload_core_rst", {31'd0, core_rst}, 32'd1);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h66, 0);
    applyStimulus(8'h77, 0);
    applyStimulus(8'h88, 0);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(8'hCC, 0);
`endif
    idle(1);
    checkOutput("t5_mem0_overwritten", dut_mem[0], 32'h88776655);
    checkOutput("t5_done", {31'd0, done}, 32'd1);

    // Largest image: NUM_WORDS words, payload contains sync bytes.
    $display("[TB] full-depth frame");
    frame_q.delete();
    for (int k = 0; k < 4 * NUM_WORDS; k++) frame_q.push_back(8'((k * 7 + 3) & 255));
    send_frame(0);
    idle(1);
    checkOutput("t6_mem0", dut_mem[0], 32'h18110A03);
    checkOutput("t6_mem_last", dut_mem[NUM_WORDS-1], 32'hFCF5EEE7);
    checkOutput("t6_done", {31'd0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Explicit checksum bytes: XOR of the two-word payload is 0x90.
    $display("[TB] checksum");
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    foreach (frame_q[i]) applyStimulus(frame_q[i], 0);
    idle(1);
    checkOutput("t7_csum_ok_done", {31'd0, done}, 32'd1);
    frame_q[11] = 8'h00;
    foreach (frame_q[i]) applyStimulus(frame_q[i], 0);
    idle(1);
    checkOutput("t7_csum_bad_error", {31'd0, error}, 32'd1);
    checkOutput("t7_csum_bad_core_rst", {31'd0, core_rst}, 32'd1);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
